// File: rtl/vt52_pkg.sv
// rtl/vt52_pkg.sv - shared constants, state enum and cell addressing for the character buffer
//   Used by both the write-side controller and the video reader so that the
//   circular row offset (first_char) is interpreted identically on both sides.
package vt52_pkg;

    localparam int COLS      = 80;
    localparam int ROWS      = 24;
    localparam int BUF_SIZE  = 1920;
    localparam int ADDR_BITS = 11;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] CR    = 8'h0D;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLEAR_LINE = 2'd1,
        CLEAR_ALL  = 2'd2
    } state_t;

    // Buffer address of screen cell (x,y) given the address of screen cell (0,0).
    // The largest raw sum is 1919 + 23*80 + 79 = 3838, so a single conditional
    // subtraction of BUF_SIZE is enough to wrap it back into range.
    function automatic logic [ADDR_BITS-1:0] cell_addr(
        input logic [ADDR_BITS-1:0] first,
        input logic [6:0]           x,
        input logic [4:0]           y
    );
        logic [11:0] sum;
        sum = {1'b0, first} + ({7'b0, y} << 6) + ({7'b0, y} << 4) + {5'b0, x};
        if (sum >= 12'(BUF_SIZE)) begin
            sum = sum - 12'(BUF_SIZE);
        end
        return sum[ADDR_BITS-1:0];
    endfunction

endpackage

// File: rtl/char_writer.sv
// rtl/char_writer.sv - write-side controller for the 80x24 circular character buffer
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready : decoded terminal byte stream (valid/ready)
//   waddr/wdata/write_en: buffer write port (never reads the buffer)
//   cursor_x/cursor_y   : cursor position on screen
//   first_char          : buffer address of screen row 0, column 0 (scroll offset)
//   busy                : a clear sequence is running (inverse of in_ready)
module char_writer
    import vt52_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ADDR_BITS-1:0] waddr,
    output logic [7:0]           wdata,
    output logic                 write_en,
    output logic [6:0]           cursor_x,
    output logic [4:0]           cursor_y,
    output logic [ADDR_BITS-1:0] first_char,
    output logic                 busy
);

    localparam logic [ADDR_BITS-1:0] LINE_LEN = ADDR_BITS'(COLS);
    localparam logic [ADDR_BITS-1:0] ALL_LEN  = ADDR_BITS'(BUF_SIZE);
    localparam logic [ADDR_BITS-1:0] MAX_BASE = ADDR_BITS'(BUF_SIZE - COLS);

    state_t               state;
    // Counts writes already issued in the current clear; shared by both clears.
    logic [ADDR_BITS-1:0] fill;
    logic [ADDR_BITS-1:0] fill_end;

    assign fill_end = (state == CLEAR_LINE) ? LINE_LEN : ALL_LEN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fill       <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            write_en   <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            cursor_x   <= '0;
            cursor_y   <= '0;
            first_char <= '0;
        end else begin
            case (state)
                IDLE: begin
                    write_en <= 1'b0;
                    if (in_valid && in_ready) begin
                        if (in_data >= SPACE && in_data <= 8'h7E) begin
                            write_en <= 1'b1;
                            waddr    <= cell_addr(first_char, cursor_x, cursor_y);
                            wdata    <= in_data;
                            // No autowrap: the last column keeps being overwritten.
                            if (cursor_x < 7'(COLS - 1)) begin
                                cursor_x <= cursor_x + 7'd1;
                            end
                        end else begin
                            case (in_data)
                                CR: cursor_x <= '0;
                                BS: if (cursor_x != '0) cursor_x <= cursor_x - 7'd1;
                                LF: begin
                                    if (cursor_y < 5'(ROWS - 1)) begin
                                        cursor_y <= cursor_y + 5'd1;
                                    end else begin
                                        // The old top row becomes the new bottom row;
                                        // its first blanking write is issued right away
                                        // so the clear fills exactly the next 80 cycles.
                                        first_char <= (first_char == MAX_BASE) ? '0
                                                      : first_char + LINE_LEN;
                                        write_en   <= 1'b1;
                                        waddr      <= first_char;
                                        wdata      <= SPACE;
                                        fill       <= ADDR_BITS'(1);
                                        in_ready   <= 1'b0;
                                        busy       <= 1'b1;
                                        state      <= CLEAR_LINE;
                                    end
                                end
                                FF: begin
                                    cursor_x   <= '0;
                                    cursor_y   <= '0;
                                    first_char <= '0;
                                    write_en   <= 1'b1;
                                    waddr      <= '0;
                                    wdata      <= SPACE;
                                    fill       <= ADDR_BITS'(1);
                                    in_ready   <= 1'b0;
                                    busy       <= 1'b1;
                                    state      <= CLEAR_ALL;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CLEAR_LINE, CLEAR_ALL: begin
                    if (fill == fill_end) begin
                        write_en <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        // A row never straddles the buffer end (1920 is a multiple
                        // of 80), so a plain increment walks the row or whole buffer.
                        write_en <= 1'b1;
                        waddr    <= waddr + ADDR_BITS'(1);
                        wdata    <= SPACE;
                        fill     <= fill + ADDR_BITS'(1);
                    end
                end
                default: begin
                    write_en <= 1'b0;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_writer.sv
// tb/tb_char_writer.sv - scoreboard testbench for char_writer
module tb_char_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] waddr;
    logic [7:0]  wdata;
    logic        write_en;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [10:0] first_char;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected buffer writes: {addr[10:0], data[7:0]}
    logic [18:0] sb[$];

    // Reference model of the cursor and scroll offset
    int mx = 0;
    int my = 0;
    int mfirst = 0;

    char_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .waddr      (waddr),
        .wdata      (wdata),
        .write_en   (write_en),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .first_char (first_char),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] exp_write(input int addr, input logic [7:0] d);
        logic [10:0] a;
        a = 11'(addr % 1920);
        return {a, d};
    endfunction

    always @(negedge clk) begin
        if (rst_n && write_en) begin
            if (sb.size() == 0) begin
                check("spurious_write", 32'(waddr), 32'hFFFF);
            end else begin
                logic [18:0] e;
                e = sb.pop_front();
                check("waddr", 32'(waddr), 32'(e[18:8]));
                check("wdata", 32'(wdata), 32'(e[7:0]));
            end
        end
    end

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            sb.push_back(exp_write(mfirst + my * 80 + mx, b));
            if (mx < 79) mx++;
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h08) begin
            if (mx > 0) mx--;
        end else if (b == 8'h0A) begin
            if (my < 23) my++;
            else begin
                for (int i = 0; i < 80; i++) sb.push_back(exp_write(mfirst + i, 8'h20));
                mfirst = (mfirst + 80) % 1920;
            end
        end else if (b == 8'h0C) begin
            mx = 0; my = 0; mfirst = 0;
            for (int i = 0; i < 1920; i++) sb.push_back(exp_write(i, 8'h20));
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        model_byte(b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("cursor_x", 32'(cursor_x), 32'(mx));
        check("cursor_y", 32'(cursor_y), 32'(my));
        check("first_char", 32'(first_char), 32'(mfirst));
    endtask

    // Called #1 after the accept edge of a clear-starting byte.
    task automatic measure_busy(input string tag, input int exp_len);
        int n;
        n = 0;
        while (!in_ready && n < 5000) begin
            check("busy_vs_ready", 32'(busy), 32'(!in_ready));
            n++;
            @(posedge clk);
            #1;
        end
        check(tag, 32'(n), 32'(exp_len));
        check("busy_after_clear", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
        check({pfx, "_write_en"}, 32'(write_en), 32'd0);
        check({pfx, "_waddr"}, 32'(waddr), 32'd0);
        check({pfx, "_wdata"}, 32'(wdata), 32'd0);
        check({pfx, "_cursor_x"}, 32'(cursor_x), 32'd0);
        check({pfx, "_cursor_y"}, 32'(cursor_y), 32'd0);
        check({pfx, "_first_char"}, 32'(first_char), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back printables
        send("A");
        send("B");
        check("ab_cursor_x", 32'(cursor_x), 32'd2);

        // Run to the last column, then overwrite it
        for (int i = 0; i < 77; i++) send(8'h61 + 8'(i % 26));
        check("col79_cursor", 32'(cursor_x), 32'd79);
        send("X");
        send("Y");
        check("no_wrap_cursor", 32'(cursor_x), 32'd79);

        // Backspace, ignored byte, carriage return
        send(8'h08);
        send(8'h01);
        send(8'h0D);

        // Line feeds down to the bottom row, then the first scroll
        for (int i = 0; i < 23; i++) send(8'h0A);
        check("bottom_row", 32'(cursor_y), 32'd23);
        send(8'h0A);
        check("scroll_ready_low", 32'(in_ready), 32'd0);
        measure_busy("line_clear_len", 80);
        check("scroll_first", 32'(first_char), 32'd80);

        // Scroll to the last row offset, then wrap
        for (int i = 0; i < 22; i++) send(8'h0A);
        measure_busy("line_clear_len_22", 80);
        check("first_1840", 32'(first_char), 32'd1840);
        send(8'h0A);
        measure_busy("wrap_clear_len", 80);
        check("first_wrapped", 32'(first_char), 32'd0);
        send("Q");

        // Full-screen clear
        send(8'h0C);
        measure_busy("full_clear_len", 1920);
        check("sb_empty_after_ff", 32'(sb.size()), 32'd0);

        // Reset in the middle of a full clear
        send(8'h0C);
        repeat (500) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        sb.delete();
        mx = 0; my = 0; mfirst = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send("Z");
        repeat (3) @(negedge clk);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/char_writer.md
# char_writer

Write-side controller for the 80x24 character buffer. It accepts decoded terminal bytes over a valid/ready stream and drives the buffer's write port (waddr/din/write_en). It tracks the cursor and publishes `first_char`, the buffer address of the top-left screen cell, so the video reader can scroll the screen without moving any data. Hardware scrolling works as a circular row offset: only the newly exposed line is blanked. Escape-sequence parsing is handled upstream; this block sees only plain control and printable bytes.

## Interface
- `COLS`, 80: characters per row.
- `ROWS`, 24: rows per screen.
- `ADDR_BITS`, 11: buffer address width; the buffer holds COLS*ROWS = 1920 entries.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  byte to process.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block can accept; a transfer occurs when `in_valid && in_ready`.
- `waddr`  out  ADDR_BITS  buffer write address.
- `wdata`  out  8  buffer write data.
- `write_en`  out  1  buffer write strobe.
- `cursor_x`  out  7  cursor column, 0..COLS-1.
- `cursor_y`  out  5  cursor row, 0..ROWS-1.
- `first_char`  out  ADDR_BITS  buffer address of screen row 0, column 0.
- `busy`  out  1  a clear sequence is in progress; equals `!in_ready`.

## Operation
- States: IDLE, CLEAR_LINE, CLEAR_ALL.
- `in_ready` is 1 only in IDLE.
- Cell address: addr(x,y) = first_char + y*COLS + x, computed 12 bits wide, then reduced by 1920 if the result is ≥ 1920. Use a shift-add for y*80 (y<<6 + y<<4); no multiplier.
- Byte handling on accept in IDLE:
  - 0x20..0x7E (printable): write `in_data` to addr(cursor_x, cursor_y). If cursor_x < COLS-1, increment it. There is no autowrap: at column 79 the cursor stays put and later characters overwrite column 79.
  - 0x0D (CR): cursor_x ← 0.
  - 0x08 (BS): decrement cursor_x if it is > 0.
  - 0x0A (LF): if cursor_y < ROWS-1, increment cursor_y. Otherwise scroll: first_char ← (first_char + 80) mod 1920, then enter CLEAR_LINE.
  - 0x0C (FF): cursor ← (0,0), first_char ← 0, enter CLEAR_ALL.
  - Any other byte: consumed with no effect.
- CLEAR_LINE: write 0x20 to the 80 addresses of the new bottom row, in increasing column order. These are the old first_char .. old first_char+79. Then return to IDLE.
- CLEAR_ALL: write 0x20 to addresses 0..1919 in ascending order, then return to IDLE.
- A single fill counter (11 bits) is shared by both clear states.
- The block never reads the buffer.

## Timing
- All outputs are registered.
- Reset values: in_ready=1, busy=0, write_en=0, waddr=0, wdata=0, cursor_x=0, cursor_y=0, first_char=0, state IDLE.
- Reset does not clear the buffer; its contents are preserved.
- Printable accepted at edge N: write_en=1 with the matching waddr/wdata during the cycle after N. The cursor update is visible after edge N. Throughput is one byte per cycle, with back-to-back writes allowed.
- Control bytes that do not start a clear take effect at the accept edge, with write_en=0.
- Scrolling LF accepted at edge N:
  - first_char updates and in_ready=0 after N.
  - Clear writes occupy the 80 cycles after N.
  - in_ready=1 in the cycle after the last write; cursor_y stays 23.
- FF accepted at edge N: 1920 write cycles follow, then in_ready returns to 1.
- A reset asserted mid-clear immediately forces write_en=0 and IDLE. The partially cleared buffer is acceptable.
- `in_data` is ignored while in_ready=0; upstream must hold the byte (standard valid/ready).

## Structure
- Shared package `vt52_pkg` holds:
  - constants COLS, ROWS, BUF_SIZE=1920, ADDR_BITS=11;
  - character codes SPACE=0x20, BS=0x08, LF=0x0A, FF=0x0C, CR=0x0D;
  - the state enum;
  - a `cell_addr(first, x, y)` function with the wrap rule, so the video reader and writer share one definition.
- No sub-module; a single module with the FSM plus fill counter.

## Test plan
- Reset, then send "AB" back-to-back: writes 0x41@0, then 0x42@1 on consecutive cycles; cursor_x=2.
- Set the cursor to column 79 (send 79 printables), then send "XY": both write to address 79; cursor_x stays 79.
- Send 23 LFs, then 1 LF:
  - the first 23 move cursor_y to 23 with no writes;
  - the 24th sets first_char=80, gives in_ready=0 for exactly 80 cycles, and writes 0x20 to addresses 0..79.
- Scroll until first_char=1840, then LF once more: first_char wraps to 0, and the clear writes addresses 1840..1919. A printable at (0,23) then writes at address 1840.
- Send FF: 1920 consecutive writes of 0x20 at addresses 0..1919; cursor, first_char=0; in_ready returns 1 on cycle 1921.
- Assert rst_n low during a CLEAR_ALL at fill count 500: write_en drops asynchronously, and all outputs show reset values. After release, a printable writes at address 0.
